// File: rtl/coreresetpf_reset_ctrl.sv
// Fabric reset controller: merges all reset sources into one fabric reset that asserts
// asynchronously and releases synchronously after a programmable delay. Flash-freeze restore
// and system services can freeze the reset state.
module coreresetpf_reset_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int RELEASE_DELAY = 2
) (
    input  logic CLK,
    input  logic EXT_RST_N,
    input  logic PLL_LOCK,
    input  logic BANK_x_VDDI_STATUS,
    input  logic BANK_y_VDDI_STATUS,
    input  logic FPGA_POR_N,
    input  logic SS_BUSY,
    input  logic INIT_DONE,
    input  logic FF_US_RESTORE,
    output logic FABRIC_RESET_N,
    output logic PLL_POWERDOWN_B
);

    localparam logic [3:0] DELAY    = 4'(RELEASE_DELAY);
    localparam logic [3:0] DELAY_M1 = (RELEASE_DELAY > 0) ? 4'(RELEASE_DELAY - 1) : 4'd0;

    logic sourcesOk;
    logic freeze;
    logic rstIntN;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             count_q, count_d;
    logic                   fabric_q, fabric_d;
    logic                   releaseNow;

    assign sourcesOk = EXT_RST_N & PLL_LOCK & INIT_DONE & BANK_x_VDDI_STATUS
                     & BANK_y_VDDI_STATUS & FPGA_POR_N;
    assign freeze    = SS_BUSY | FF_US_RESTORE;

    // Single AND/OR level; this net only ever feeds asynchronous clears.
    assign rstIntN   = sourcesOk | freeze;

    // With no extra delay the fabric reset releases on the same edge the synchronizer completes.
    generate
        if (RELEASE_DELAY == 0) begin : g_noDelay
            assign releaseNow = sync_q[SYNC_STAGES-2];
        end else begin : g_delay
            assign releaseNow = sync_q[SYNC_STAGES-1] && (count_q == DELAY_M1);
        end
    endgenerate

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b1};
        count_d  = count_q;
        if (sync_q[SYNC_STAGES-1] && (count_q != DELAY)) begin
            count_d = count_q + 4'd1;
        end
        fabric_d = fabric_q | releaseNow;
    end

    // Freeze holds every release flop so a paused sequence resumes where it stopped.
    always_ff @(posedge CLK or negedge rstIntN) begin
        if (!rstIntN) begin
            sync_q   <= '0;
            count_q  <= 4'd0;
            fabric_q <= 1'b0;
        end else if (!freeze) begin
            sync_q   <= sync_d;
            count_q  <= count_d;
            fabric_q <= fabric_d;
        end
    end

    assign FABRIC_RESET_N  = fabric_q;
    assign PLL_POWERDOWN_B = FPGA_POR_N & BANK_y_VDDI_STATUS;

endmodule

// File: tb/tb_coreresetpf_reset_ctrl.sv
// Directed bench for coreresetpf_reset_ctrl: a clock-stopped vector table for the
// asynchronous paths plus hand-written release, freeze and abort sequences.
module tb_coreresetpf_reset_ctrl;

    logic CLK = 1'b0;
    logic clkRun = 1'b1;
    logic EXT_RST_N, PLL_LOCK, BANK_x_VDDI_STATUS, BANK_y_VDDI_STATUS;
    logic FPGA_POR_N, SS_BUSY, INIT_DONE, FF_US_RESTORE;
    logic FABRIC_RESET_N, PLL_POWERDOWN_B;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic extRstN, pllLock, initDone, bankX, bankY, porN, ssBusy, ffRestore;
        logic expFabric, expPll;
    } vec_t;

    vec_t vecs [10];

    coreresetpf_reset_ctrl dut (
        .CLK                (CLK),
        .EXT_RST_N          (EXT_RST_N),
        .PLL_LOCK           (PLL_LOCK),
        .BANK_x_VDDI_STATUS (BANK_x_VDDI_STATUS),
        .BANK_y_VDDI_STATUS (BANK_y_VDDI_STATUS),
        .FPGA_POR_N         (FPGA_POR_N),
        .SS_BUSY            (SS_BUSY),
        .INIT_DONE          (INIT_DONE),
        .FF_US_RESTORE      (FF_US_RESTORE),
        .FABRIC_RESET_N     (FABRIC_RESET_N),
        .PLL_POWERDOWN_B    (PLL_POWERDOWN_B)
    );

    always #5 CLK = clkRun ? ~CLK : 1'b0;

    // Freeze inputs go first so a frozen-to-frozen step never glitches an async reset.
    task automatic applyStimulus(input vec_t v);
        SS_BUSY            = v.ssBusy;
        FF_US_RESTORE      = v.ffRestore;
        EXT_RST_N          = v.extRstN;
        PLL_LOCK           = v.pllLock;
        INIT_DONE          = v.initDone;
        BANK_x_VDDI_STATUS = v.bankX;
        BANK_y_VDDI_STATUS = v.bankY;
        FPGA_POR_N         = v.porN;
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts rising edges until FABRIC_RESET_N goes high, bounded at 16; 0 means it never did.
    task automatic releaseCheck(input string name, input int expEdges);
        int firstEdge = 0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge CLK);
            #1;
            if (FABRIC_RESET_N === 1'b1) begin
                firstEdge = e;
                break;
            end
        end
        checkValue(name, firstEdge, expEdges);
    endtask

    task automatic runEdges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        vecs[0] = '{1,1,1,1,1,1,0,0, 1,1};
        vecs[1] = '{0,1,1,1,1,1,0,1, 1,1};
        vecs[2] = '{0,1,1,1,1,1,1,0, 1,1};
        vecs[3] = '{0,1,1,1,1,1,0,0, 0,1};
        vecs[4] = '{1,1,1,1,0,0,0,0, 0,0};
        vecs[5] = '{1,1,1,1,1,0,0,0, 0,0};
        vecs[6] = '{1,1,1,1,1,1,0,0, 0,1};
        vecs[7] = '{1,1,1,1,0,1,0,0, 0,0};
        vecs[8] = '{1,1,1,0,1,1,1,0, 0,1};
        vecs[9] = '{1,1,1,1,1,1,0,0, 0,1};

        applyStimulus(vecs[0]);
        #2;
        EXT_RST_N = 1'b0;
        #1;
        checkOutput("reset_fabric", FABRIC_RESET_N, 1'b0);
        checkOutput("reset_pll", PLL_POWERDOWN_B, 1'b1);
        runEdges(3);
        checkOutput("reset_held", FABRIC_RESET_N, 1'b0);
        EXT_RST_N = 1'b1;
        releaseCheck("ext_release_latency", 4);

        // Clock stopped: only asynchronous behaviour can change the outputs.
        @(negedge CLK);
        clkRun = 1'b0;
        #20;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_fabric", i), FABRIC_RESET_N, vecs[i].expFabric);
            checkOutput($sformatf("vec%0d_pll", i), PLL_POWERDOWN_B, vecs[i].expPll);
            #99;
        end
        clkRun = 1'b1;
        releaseCheck("table_restart_latency", 4);

        PLL_LOCK = 1'b0;
        #1;
        checkOutput("pll_unlock_async", FABRIC_RESET_N, 1'b0);
        runEdges(3);
        checkOutput("pll_unlock_held", FABRIC_RESET_N, 1'b0);
        PLL_LOCK = 1'b1;
        releaseCheck("pll_relock_latency", 4);

        INIT_DONE = 1'b0;
        #1;
        checkOutput("init_low_async", FABRIC_RESET_N, 1'b0);
        runEdges(3);
        checkOutput("init_low_held", FABRIC_RESET_N, 1'b0);
        INIT_DONE = 1'b1;
        releaseCheck("init_done_latency", 4);

        FF_US_RESTORE = 1'b1;
        EXT_RST_N     = 1'b0;
        runEdges(3);
        checkOutput("freeze_hold_high", FABRIC_RESET_N, 1'b1);
        FF_US_RESTORE = 1'b0;
        #1;
        checkOutput("freeze_drop_assert", FABRIC_RESET_N, 1'b0);
        EXT_RST_N = 1'b1;
        releaseCheck("freeze_release_latency", 4);

        // Abort two edges into the release, then demand the full sequence again.
        EXT_RST_N = 1'b0;
        #1;
        EXT_RST_N = 1'b1;
        runEdges(2);
        PLL_LOCK = 1'b0;
        #1;
        checkOutput("abort_async", FABRIC_RESET_N, 1'b0);
        runEdges(2);
        checkOutput("abort_held", FABRIC_RESET_N, 1'b0);
        PLL_LOCK = 1'b1;
        releaseCheck("abort_restart_latency", 4);

        // Pause two edges into the release; resuming needs only the remaining two.
        EXT_RST_N = 1'b0;
        #1;
        EXT_RST_N = 1'b1;
        runEdges(2);
        SS_BUSY = 1'b1;
        runEdges(5);
        checkOutput("pause_held", FABRIC_RESET_N, 1'b0);
        SS_BUSY = 1'b0;
        releaseCheck("pause_resume_latency", 2);

        EXT_RST_N = 1'b0;
        #1;
        EXT_RST_N = 1'b1;
        runEdges(2);
        @(posedge CLK);
        @(posedge CLK);
        EXT_RST_N = 1'b0;
        #1;
        checkOutput("simultaneous_drop", FABRIC_RESET_N, 1'b0);
        EXT_RST_N = 1'b1;
        releaseCheck("simultaneous_recover", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
